// File: rtl/systolic_input_skewer.sv
// Purpose : re-times one full row vector per handshake into the diagonal
//           wavefront a systolic array needs (lane k delayed k extra cycles),
//           then drains the skew pipeline and reports the tile length.
// Latency : vector accepted at edge t shows on lane k in cycle t+1+k;
//           tile_done_o fires in cycle t+ARRAY_SIZE after the last vector.
// Backpressure: in_ready_o is low only while draining (ARRAY_SIZE-1 cycles);
//           the array side has no backpressure and consumes every cycle.
//
// Ports:
//   clk_i, rst_ni          clock (rising edge), async active-low reset
//   in_valid_i/in_ready_o  upstream vector handshake
//   in_data_i              row vector, lane k = [k*DATA_WIDTH +: DATA_WIDTH]
//   in_last_i              final vector of the tile (sampled on accept only)
//   out_data_o/out_valid_o skewed lanes and per-lane valids to the array
//   tile_done_o            one-cycle pulse when the last lane of the tile leaves
//   tile_len_o             vectors in the completed tile (saturating), held
//   busy_o                 high while a tile is streaming or draining
module systolic_input_skewer #(
   parameter  int ARRAY_SIZE  = 4,
   parameter  int DATA_WIDTH  = 8,
   parameter  int MAX_VECTORS = 255,
   localparam int LEN_W       = $clog2(MAX_VECTORS + 1),
   localparam int DRN_W       = $clog2(ARRAY_SIZE)
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             in_valid_i,
   output logic                             in_ready_o,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_data_i,
   input  logic                             in_last_i,
   output logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_data_o,
   output logic [ARRAY_SIZE-1:0]            out_valid_o,
   output logic                             tile_done_o,
   output logic [LEN_W-1:0]                 tile_len_o,
   output logic                             busy_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   // Drain lasts ARRAY_SIZE-1 cycles: load N-2 and count down to zero inclusive.
   localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(ARRAY_SIZE - 2);
   localparam logic [LEN_W-1:0] LEN_MAX    = LEN_W'(MAX_VECTORS);

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  vec_cnt_q, vec_cnt_d;
   logic [DRN_W-1:0]  drain_cnt_q, drain_cnt_d;
   logic              tile_done_q, tile_done_d;
   logic [LEN_W-1:0]  tile_len_q, tile_len_d;
   logic              accept;

   // Ready depends on state only, never on in_valid_i.
   assign in_ready_o  = (state_q != DRAIN);
   assign busy_o      = (state_q != IDLE);
   assign accept      = in_valid_i & in_ready_o;
   assign tile_done_o = tile_done_q;
   assign tile_len_o  = tile_len_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         vec_cnt_q   <= '0;
         drain_cnt_q <= '0;
         tile_done_q <= 1'b0;
         tile_len_q  <= '0;
      end else begin
         state_q     <= state_d;
         vec_cnt_q   <= vec_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         tile_done_q <= tile_done_d;
         tile_len_q  <= tile_len_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      vec_cnt_d   = vec_cnt_q;
      drain_cnt_d = drain_cnt_q;
      tile_done_d = 1'b0;
      tile_len_d  = tile_len_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               vec_cnt_d = LEN_W'(1);
               if (in_last_i) begin
                  state_d     = DRAIN;
                  drain_cnt_d = DRAIN_LOAD;
               end else begin
                  state_d = STREAM;
               end
            end
         end
         STREAM: begin
            if (accept) begin
               // Saturate; data keeps streaming past the counter limit.
               if (vec_cnt_q != LEN_MAX) begin
                  vec_cnt_d = vec_cnt_q + 1'b1;
               end
               if (in_last_i) begin
                  state_d     = DRAIN;
                  drain_cnt_d = DRAIN_LOAD;
               end
            end
         end
         DRAIN: begin
            // Registered pulse lands in the cycle the last lane presents
            // the final vector, which is also the first IDLE cycle.
            if (drain_cnt_q == '0) begin
               state_d     = IDLE;
               tile_done_d = 1'b1;
               tile_len_d  = vec_cnt_q;
            end else begin
               drain_cnt_d = drain_cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Lane k is a chain of k+1 registers. Non-accept cycles inject a zero
   // bubble, so a lane's data is zero whenever its valid is low.
   for (genvar k = 0; k < ARRAY_SIZE; k++) begin : g_lane
      logic [k:0][DATA_WIDTH-1:0] dat_q;
      logic [k:0]                 vld_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            dat_q <= '0;
            vld_q <= '0;
         end else begin
            dat_q[0] <= accept ? in_data_i[k*DATA_WIDTH +: DATA_WIDTH] : '0;
            vld_q[0] <= accept;
            for (int s = 1; s <= k; s++) begin
               dat_q[s] <= dat_q[s-1];
               vld_q[s] <= vld_q[s-1];
            end
         end
      end

      assign out_data_o[k*DATA_WIDTH +: DATA_WIDTH] = dat_q[k];
      assign out_valid_o[k]                         = vld_q[k];
   end

endmodule

// File: tb/tb_systolic_input_skewer.sv
// Purpose : directed bench for systolic_input_skewer; two instances share the
//           stimulus, one default (MAX_VECTORS=255) and one with MAX_VECTORS=3.
// Expected lane data is queued with its due cycle when a vector is accepted
// and popped when that cycle is observed.
module tb_systolic_input_skewer;
   localparam int N  = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_last;
   logic [N*DW-1:0] in_data;

   logic          in_ready_a, tile_done_a, busy_a;
   logic [N*DW-1:0] out_data_a;
   logic [N-1:0]  out_valid_a;
   logic [7:0]    tile_len_a;

   logic          in_ready_b, tile_done_b, busy_b;
   logic [N*DW-1:0] out_data_b;
   logic [N-1:0]  out_valid_b;
   logic [1:0]    tile_len_b;

   always #5 clk = ~clk;

   systolic_input_skewer #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .MAX_VECTORS(255)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready_a),
      .in_data_i(in_data), .in_last_i(in_last), .out_data_o(out_data_a),
      .out_valid_o(out_valid_a), .tile_done_o(tile_done_a), .tile_len_o(tile_len_a),
      .busy_o(busy_a));

   systolic_input_skewer #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .MAX_VECTORS(3)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready_b),
      .in_data_i(in_data), .in_last_i(in_last), .out_data_o(out_data_b),
      .out_valid_o(out_valid_b), .tile_done_o(tile_done_b), .tile_len_o(tile_len_b),
      .busy_o(busy_b));

   typedef struct {
      int         cyc;
      int         lane;
      logic [7:0] d;
   } exp_t;

   exp_t exp_q[$];

   int   checks, failures;
   int   now, ready_cyc, done_cyc;
   int   cnt_a, cnt_b;
   bit   done_pend, in_tile;
   logic [7:0] len_a;
   logic [1:0] len_b;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic reset_checks();
      chk("rst_out_valid_a", out_valid_a, 0);
      chk("rst_out_data_a",  out_data_a,  0);
      chk("rst_tile_done_a", tile_done_a, 0);
      chk("rst_tile_len_a",  tile_len_a,  0);
      chk("rst_busy_a",      busy_a,      0);
      chk("rst_in_ready_a",  in_ready_a,  1);
      chk("rst_out_valid_b", out_valid_b, 0);
      chk("rst_out_data_b",  out_data_b,  0);
      chk("rst_tile_len_b",  tile_len_b,  0);
      chk("rst_busy_b",      busy_b,      0);
   endtask

   // Compare all outputs for cycle 'now' against the scoreboard and model.
   task automatic check_outputs();
      logic [N-1:0]    ev;
      logic [N*DW-1:0] ed;
      bit              exp_done;
      ev = '0;
      ed = '0;
      for (int k = 0; k < N; k++) begin
         for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].cyc == now && exp_q[i].lane == k) begin
               ev[k] = 1'b1;
               ed[k*DW +: DW] = exp_q[i].d;
               exp_q.delete(i);
               break;
            end
         end
      end
      exp_done = done_pend && (now == done_cyc);
      if (exp_done) begin
         done_pend = 0;
         in_tile   = 0;
         len_a     = 8'(cnt_a);
         len_b     = 2'(cnt_b);
      end
      chk("out_valid_a", out_valid_a, ev);
      chk("out_data_a",  out_data_a,  ed);
      chk("out_valid_b", out_valid_b, ev);
      chk("out_data_b",  out_data_b,  ed);
      chk("tile_done_a", tile_done_a, exp_done);
      chk("tile_done_b", tile_done_b, exp_done);
      chk("tile_len_a",  tile_len_a,  len_a);
      chk("tile_len_b",  tile_len_b,  len_b);
      chk("busy_a",      busy_a,      in_tile);
      chk("busy_b",      busy_b,      in_tile);
   endtask

   // One clock cycle: entered and left at the falling edge.
   task automatic step(input logic v, input logic l, input logic [N*DW-1:0] d);
      bit m_ready, acc;
      m_ready  = (now >= ready_cyc);
      in_valid = v;
      in_last  = l;
      in_data  = d;
      #1;
      chk("in_ready_a", in_ready_a, m_ready);
      chk("in_ready_b", in_ready_b, m_ready);
      acc = v && m_ready;
      @(posedge clk);
      now++;
      if (acc) begin
         for (int k = 0; k < N; k++) begin
            exp_t e;
            e.cyc  = now + k;
            e.lane = k;
            e.d    = d[k*DW +: DW];
            exp_q.push_back(e);
         end
         if (!in_tile) begin
            cnt_a = 1;
            cnt_b = 1;
         end else begin
            if (cnt_a < 255) cnt_a++;
            if (cnt_b < 3)   cnt_b++;
         end
         in_tile = 1;
         if (l) begin
            ready_cyc = now + N - 1;
            done_cyc  = now + N - 1;
            done_pend = 1;
         end
      end
      @(negedge clk);
      check_outputs();
   endtask

   // Idle until the model says the skewer is ready, then offer one vector.
   task automatic send(input logic l, input logic [N*DW-1:0] d);
      int guard;
      guard = 0;
      while (now < ready_cyc && guard < 20) begin
         step(1'b0, 1'b0, '0);
         guard++;
      end
      chk("send_wait_bound", guard < 20, 1);
      step(1'b1, l, d);
   endtask

   initial begin
      checks = 0; failures = 0; now = 0; ready_cyc = 0; done_cyc = 0;
      cnt_a = 0; cnt_b = 0; done_pend = 0; in_tile = 0; len_a = '0; len_b = '0;

      // Reset with active-looking inputs; they must be ignored.
      rst_n = 1'b0; in_valid = 1'b1; in_last = 1'b1; in_data = 32'hdeadbeef;
      repeat (3) @(negedge clk);
      reset_checks();
      in_valid = 1'b0; in_last = 1'b0; in_data = '0;
      rst_n = 1'b1;
      repeat (5) step(1'b0, 1'b0, '0);

      // Single-vector tile.
      send(1'b1, 32'h44332211);
      repeat (5) step(1'b0, 1'b0, '0);

      // Three-vector tile followed at once by a two-vector tile.
      send(1'b0, 32'ha3a2a1a0);
      send(1'b0, 32'hb3b2b1b0);
      send(1'b1, 32'hc3c2c1c0);
      send(1'b0, 32'hd3d2d1d0);
      send(1'b1, 32'he3e2e1e0);
      repeat (6) step(1'b0, 1'b0, '0);

      // Bubble inside a tile; in_last without in_valid must not end it.
      send(1'b0, 32'h13121110);
      step(1'b0, 1'b1, 32'hffffffff);
      send(1'b1, 32'h23222120);
      repeat (6) step(1'b0, 1'b0, '0);

      // Async reset mid-drain with lanes 2 and 3 both valid.
      send(1'b0, 32'h33323130);
      send(1'b0, 32'h43424140);
      send(1'b1, 32'h53525150);
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      chk("pre_reset_lanes23", out_valid_a[3:2], 2'b11);
      #2 rst_n = 1'b0;
      #1;
      reset_checks();
      exp_q.delete();
      done_pend = 0; in_tile = 0; ready_cyc = 0; len_a = '0; len_b = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) step(1'b0, 1'b0, '0);

      // Five-vector tile: saturates the MAX_VECTORS=3 instance.
      for (int i = 0; i < 5; i++) begin
         logic [7:0] b;
         b = 8'(8'h60 + 8'(i * 4));
         send(i == 4, {b + 8'd3, b + 8'd2, b + 8'd1, b});
      end
      repeat (6) step(1'b0, 1'b0, '0);
      chk("final_len_a", tile_len_a, 5);
      chk("final_len_b", tile_len_b, 3);

      chk("scoreboard_empty", exp_q.size(), 0);
      chk("no_pending_done", done_pend, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/systolic_input_skewer.md
Name: systolic_input_skewer

Overview:
- Upstream feeder for the systolic array in the tpu top.
- Accepts one full row vector (ARRAY_SIZE lanes) per handshake and re-times it into the diagonal wavefront the array needs: lane k is delayed k extra cycles.
- At the end of a tile it flushes the skew pipeline and pulses a completion strobe with the tile length.
- The array side has no back-pressure; the array consumes every cycle.

Parameters:
- ARRAY_SIZE, 4, number of lanes / array rows; legal range 2..16.
- DATA_WIDTH, 8, bits per lane element.
- MAX_VECTORS, 255, largest tile length counted; sets the width of tile_len.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream vector valid.
- in_ready  out  1  skewer can accept a vector.
- in_data  in  ARRAY_SIZE*DATA_WIDTH  row vector; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH].
- in_last  in  1  qualifies the final vector of a tile; sampled only on accept.
- out_data  out  ARRAY_SIZE*DATA_WIDTH  skewed lanes to array row inputs.
- out_valid  out  ARRAY_SIZE  per-lane valid.
- tile_done  out  1  one-cycle pulse when the last lane of the last vector is presented.
- tile_len  out  clog2(MAX_VECTORS+1)  vectors in the completed tile; valid with tile_done, held until the next tile_done.
- busy  out  1  high in STREAM or DRAIN.

Behaviour:
- Reset (reset=0, async): state=IDLE; all skew registers cleared; out_data=0, out_valid=0, tile_done=0, tile_len=0, busy=0, vector counter=0. Inputs are ignored while reset=0. On deassertion the block is usable on the first clock edge.
- Accept: accept = in_valid & in_ready. in_ready = (state != DRAIN), combinational from state only; it never depends on in_valid.
- Skew pipeline:
  - Lane k is a chain of k+1 registers.
  - A vector accepted at edge t appears on lane k at cycle t+1+k, with out_valid[k]=1.
  - Cycles without accept inject a bubble: data 0, valid 0.
  - out_data lane k is 0 whenever out_valid[k]=0.
  - Data passes through unmodified; no arithmetic.
- States:
  - IDLE:
    - accept & !in_last -> STREAM; counter=1.
    - accept & in_last -> DRAIN; counter=1 (single-vector tile).
  - STREAM:
    - accept & !in_last -> stay; counter++.
    - accept & in_last -> DRAIN; counter++.
    - no accept -> stay (bubbles only).
  - DRAIN:
    - Lasts exactly ARRAY_SIZE-1 cycles, counted by a drain counter; in_ready=0.
    - On the cycle the drain counter expires: state -> IDLE, and tile_done=1 for that one cycle.
    - tile_len is registered with the counter value on that same cycle.
- Timing: last vector accepted at edge t → DRAIN covers cycles t+1..t+ARRAY_SIZE-1; tile_done, the tile_len update, and out_valid[ARRAY_SIZE-1] of the last vector all occur in cycle t+ARRAY_SIZE; in_ready is high again in that cycle.
- Back-to-back tiles: a new vector may be accepted in the tile_done cycle (IDLE). Its lane-0 output at cycle t+ARRAY_SIZE+1 follows the previous tile's wavefront with no overlap on any lane.
- Counter: saturates at MAX_VECTORS. Further accepts still stream data correctly; tile_len reports MAX_VECTORS.
- busy: 1 in STREAM/DRAIN, 0 in IDLE. It is 0 during the tile_done cycle.
- Reset mid-tile: all in-flight lane data, valids and counters clear immediately; no tile_done is generated for the aborted tile.
- in_last with in_valid=0 has no effect.

Test Plan (ARRAY_SIZE=4, DATA_WIDTH=8):
- Reset then idle 5 cycles → out_valid=0000, out_data=0, in_ready=1, busy=0, tile_done never asserted.
- Single vector {lane3..0}=8'h44,33,22,11 with in_last accepted at edge 0 → lane0=8'h11 cycle 1, lane1=8'h22 cycle 2, lane2=8'h33 cycle 3, lane3=8'h44 cycle 4; in_ready=0 cycles 1-3; tile_done=1 and tile_len=1 cycle 4.
- Three vectors back-to-back (last on third), then a second 2-vector tile immediately → first tile_done at cycle 6 with tile_len=3; the second tile's first accept happens in cycle 6; no lane ever shows both tiles' data in one cycle; second tile_len=2.
- in_valid toggling 1,0,1 within a tile → bubble appears as out_valid=0/data 0 on each lane, skewed by one cycle per lane.
- reset pulsed low asynchronously (mid-cycle) while in DRAIN with lanes 2-3 still valid → outputs zero immediately, no tile_done, and in_ready=1 after release.
- MAX_VECTORS=3 override, 5-vector tile → tile_len=3 at tile_done; all 5 vectors appear correctly skewed.
